// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game datapath: FSM state encoding,
// screen/ball geometry and the level-0 brick map with its brick count.
package breakout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  localparam int H       = 640;
  localparam int V       = 480;
  localparam int BALL_W  = 16;
  localparam int BALL_H  = 10;
  localparam int BOARD_Y = 467;

  // Brick map: 480 fields of 3 bits, 20 fields per row, field i at [3i+2:3i]
  localparam int NUM_FIELDS = 480;
  localparam int FIELD_W    = 3;
  localparam int MAP_W      = NUM_FIELDS * FIELD_W;

  // Parked-ball position relative to the paddle and the "ball lost" line
  localparam int PARK_X_OFS = 40;
  localparam int PARK_Y     = 455;
  localparam int LOST_Y     = 530;

  // Level 0: the top five rows (fields 0..99) hold type-1 bricks
  localparam logic [MAP_W-1:0] LEVEL0_MAP   = {{380{3'b000}}, {100{3'b001}}};
  localparam logic [8:0]       LEVEL0_COUNT = 9'd100;

endpackage

// File: rtl/brick_clear_counter.sv
// Counts brick fields that are occupied in the current map and empty in the
// map proposed for the next frame, i.e. bricks destroyed this step.
module brick_clear_counter
  import breakout_pkg::*;
(
  input  logic [MAP_W-1:0] i_bricks,
  input  logic [MAP_W-1:0] i_next_bricks,
  output logic [8:0]       o_cleared
);

  logic [NUM_FIELDS-1:0] w_gone;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign w_gone[gi] = (|i_bricks[gi*FIELD_W +: FIELD_W]) &&
                          !(|i_next_bricks[gi*FIELD_W +: FIELD_W]);
    end
  endgenerate

  // Population count of destroyed fields
  always_comb begin
    o_cleared = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      o_cleared = o_cleared + 9'(w_gone[i]);
    end
  end

endmodule

// File: rtl/ball_state_ctrl.sv
// Game-state controller for breakout: registers ball/brick state from the
// ball_control stage each frame, tracks lives/score/bricks left and runs the
// IDLE/SERVE/PLAY/OVER/CLEAR flow. Optional macro BALL_SPEEDUP_EN bumps the
// vertical speed each time the score passes a multiple of 32.
module ball_state_ctrl
  import breakout_pkg::*;
#(
  parameter int INIT_LIVES = 3,
  parameter int BALL_VX0   = 4,
  parameter int BALL_VY0   = 3
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             launch_btn,
  input  logic [9:0]       board_x,
  input  logic [MAP_W-1:0] next_bricks,
  input  logic [9:0]       next_ball_x,
  input  logic [9:0]       next_ball_y,
  input  logic [9:0]       next_ball_vx,
  input  logic [9:0]       next_ball_vy,
  input  logic [1:0]       next_ball_dir,
  input  logic             collision_trig,
  output logic [MAP_W-1:0] bricks,
  output logic [9:0]       ball_x,
  output logic [9:0]       ball_y,
  output logic [9:0]       ball_vx,
  output logic [9:0]       ball_vy,
  output logic [1:0]       ball_dir,
  output logic [2:0]       state,
  output logic [1:0]       lives,
  output logic [11:0]      score,
  output logic [8:0]       bricks_left,
  output logic             hit_pulse,
  output logic             game_over
);

  state_t           r_state, w_state_next;
  logic [MAP_W-1:0] r_bricks, w_bricks_next;
  logic [9:0]       r_x, r_y, r_vx, r_vy;
  logic [9:0]       w_x_next, w_y_next, w_vx_next, w_vy_next;
  logic [1:0]       r_dir, w_dir_next;
  logic [1:0]       r_lives, w_lives_next;
  logic [11:0]      r_score, w_score_next;
  logic [8:0]       r_left, w_left_next;
  logic             r_hit, w_hit_next;
  logic             r_pend, w_pend_next;

  logic [8:0]       w_cleared;
  logic [12:0]      w_score_sum;
  logic [11:0]      w_score_sat;
  logic [8:0]       w_left_sub;
  logic [11:0]      w_bottom;
  logic             w_lost;
  logic [9:0]       w_vy_play;

  brick_clear_counter u_clear_cnt (
    .i_bricks      (r_bricks),
    .i_next_bricks (next_bricks),
    .o_cleared     (w_cleared)
  );

  assign w_score_sum = {1'b0, r_score} + {4'b0, w_cleared};
  assign w_score_sat = w_score_sum[12] ? 12'hFFF : w_score_sum[11:0];
  assign w_left_sub  = (w_cleared >= r_left) ? 9'd0 : r_left - w_cleared;
  // Lost check uses the currently registered ball, before this tick's update
  assign w_bottom    = {2'b0, r_y} + 12'(BALL_H) + {2'b0, r_vy};
  assign w_lost      = r_dir[0] && (w_bottom > 12'(LOST_Y));

`ifdef BALL_SPEEDUP_EN
  logic w_cross32;
  assign w_cross32 = (w_score_sat[11:5] != r_score[11:5]);
  assign w_vy_play = (w_cross32 && (next_ball_vy < 10'd7)) ? next_ball_vy + 10'd1
                                                           : next_ball_vy;
`else
  assign w_vy_play = next_ball_vy;
`endif

  // Next-state and next-datapath logic; everything holds unless a rule fires
  always_comb begin
    w_state_next  = r_state;
    w_bricks_next = r_bricks;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_vx_next     = r_vx;
    w_vy_next     = r_vy;
    w_dir_next    = r_dir;
    w_lives_next  = r_lives;
    w_score_next  = r_score;
    w_left_next   = r_left;
    w_hit_next    = 1'b0;
    w_pend_next   = r_pend;
    case (r_state)
      ST_IDLE, ST_SERVE: begin
        if (launch_btn) w_pend_next = 1'b1;
        if (frame_tick) begin
          w_x_next   = board_x + 10'(PARK_X_OFS);
          w_y_next   = 10'(PARK_Y);
          w_dir_next = 2'b10;
          w_vx_next  = 10'(BALL_VX0);
          w_vy_next  = 10'(BALL_VY0);
          // A launch on the tick cycle itself counts as launch-then-tick
          if (r_pend || launch_btn) begin
            w_state_next = ST_PLAY;
            w_pend_next  = 1'b0;
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          w_hit_next    = collision_trig;
          w_bricks_next = next_bricks;
          w_x_next      = next_ball_x;
          w_y_next      = next_ball_y;
          w_vx_next     = next_ball_vx;
          w_vy_next     = w_vy_play;
          w_dir_next    = next_ball_dir;
          w_score_next  = w_score_sat;
          w_left_next   = w_left_sub;
          // Clearing the level wins over losing the ball on the same tick
          if (w_left_sub == 9'd0) begin
            w_state_next = ST_CLEAR;
          end else if (w_lost) begin
            w_lives_next = r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              w_state_next = ST_OVER;
            end else begin
              w_state_next = ST_SERVE;
              w_x_next     = board_x + 10'(PARK_X_OFS);
              w_y_next     = 10'(PARK_Y);
              w_dir_next   = 2'b10;
              w_vx_next    = 10'(BALL_VX0);
              w_vy_next    = 10'(BALL_VY0);
            end
          end
        end
      end
      ST_OVER, ST_CLEAR: begin
        if (launch_btn) begin
          w_state_next  = ST_IDLE;
          w_bricks_next = LEVEL0_MAP;
          w_lives_next  = 2'(INIT_LIVES);
          w_score_next  = 12'd0;
          w_left_next   = LEVEL0_COUNT;
          w_pend_next   = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Ball, brick and scoring registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bricks <= LEVEL0_MAP;
      r_x      <= 10'(PARK_X_OFS);
      r_y      <= 10'(PARK_Y);
      r_vx     <= 10'(BALL_VX0);
      r_vy     <= 10'(BALL_VY0);
      r_dir    <= 2'b10;
      r_lives  <= 2'(INIT_LIVES);
      r_score  <= 12'd0;
      r_left   <= LEVEL0_COUNT;
      r_hit    <= 1'b0;
      r_pend   <= 1'b0;
    end else begin
      r_bricks <= w_bricks_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_vx     <= w_vx_next;
      r_vy     <= w_vy_next;
      r_dir    <= w_dir_next;
      r_lives  <= w_lives_next;
      r_score  <= w_score_next;
      r_left   <= w_left_next;
      r_hit    <= w_hit_next;
      r_pend   <= w_pend_next;
    end
  end

  assign bricks      = r_bricks;
  assign ball_x      = r_x;
  assign ball_y      = r_y;
  assign ball_vx     = r_vx;
  assign ball_vy     = r_vy;
  assign ball_dir    = r_dir;
  assign state       = r_state;
  assign lives       = r_lives;
  assign score       = r_score;
  assign bricks_left = r_left;
  assign hit_pulse   = r_hit;
  assign game_over   = (r_state == ST_OVER);

endmodule

// File: doc/ball_state_ctrl.md
BALL_STATE_CTRL -- requirements
Module: ball_state_ctrl

Interface
REQ-001 Parameter INIT_LIVES, default 3: lives loaded at game start (1..3).
REQ-002 Parameter BALL_VX0, default 4: launch horizontal speed.
REQ-003 Parameter BALL_VY0, default 3: launch vertical speed.
REQ-004 clk  in  1: single system clock; all state changes on rising edge.
REQ-005 rst_n  in  1: asynchronous, active-low reset.
REQ-006 frame_tick  in  1: one-cycle game-step strobe (about 60 Hz).
REQ-007 launch_btn  in  1: debounced one-cycle launch/restart request.
REQ-008 board_x  in  10: paddle left x.
REQ-009 next_bricks  in  1440: brick map from the ball_control stage (480 fields × 3 bits, 20 per row).
REQ-010 next_ball_x, next_ball_y, next_ball_vx, next_ball_vy  in  10 each: next ball kinematics from ball_control.
REQ-011 next_ball_dir  in  2: next direction from ball_control; bit1 = right, bit0 = down.
REQ-012 collision_trig  in  1: collision flag from ball_control.
REQ-013 bricks  out  1440: registered brick map, fed back to ball_control.
REQ-014 ball_x, ball_y, ball_vx, ball_vy  out  10 each; ball_dir  out  2: registered ball state, fed back to ball_control.
REQ-015 state  out  3: FSM state; lives  out  2; score  out  12; bricks_left  out  9.
REQ-016 hit_pulse  out  1: one-cycle collision strobe for sound.
REQ-017 game_over  out  1: high in OVER state.

Function
REQ-018 States SHALL be IDLE=0, SERVE=1, PLAY=2, OVER=3, CLEAR=4.
REQ-019 IDLE/SERVE: on every frame_tick, ball_x SHALL = board_x+40, ball_y = 455, ball_dir = 2'b10, ball_vx = BALL_VX0, ball_vy = BALL_VY0; bricks held.
REQ-020 A launch_btn in IDLE/SERVE SHALL set a pending flag; the next frame_tick SHALL clear it and enter PLAY; a launch and tick in the same cycle SHALL count as launch-then-tick.
REQ-021 PLAY, on frame_tick: all next_* inputs SHALL be registered into the outputs on that same edge (latency 1 edge); non-tick cycles SHALL hold.
REQ-022 cleared = count of 3-bit fields nonzero in bricks and zero in next_bricks (0..480); score SHALL add cleared, saturating at 4095; bricks_left SHALL subtract cleared, floored at 0.
REQ-023 lost = ball_dir[0] && (ball_y + 10 + ball_vy > 530), evaluated on registered values at the tick.
REQ-024 On lost: lives SHALL decrement; if lives was 1 → OVER, else → SERVE, ball parked per REQ-019.
REQ-025 If bricks_left reaches 0 at a tick → CLEAR; CLEAR SHALL take priority over lost in the same tick, and lives SHALL stay unchanged.
REQ-026 hit_pulse SHALL be 1 for exactly the cycle after a PLAY tick with collision_trig = 1; otherwise 0.
REQ-027 OVER/CLEAR: all outputs SHALL be frozen; launch_btn SHALL → IDLE with bricks = LEVEL0_MAP, lives = INIT_LIVES, score = 0, bricks_left = count of LEVEL0_MAP.
REQ-028 launch_btn SHALL be ignored in PLAY.

Reset
REQ-029 rst_n low SHALL immediately set state = IDLE, bricks = LEVEL0_MAP, ball parked at x = 40, y = 455, dir = 2'b10, vx/vy = BALL_VX0/BALL_VY0, lives = INIT_LIVES, score = 0, bricks_left = LEVEL0_COUNT, hit_pulse = 0, pending = 0.
REQ-030 Reset asserted mid-PLAY SHALL discard any pending tick or launch; operation SHALL resume in IDLE after release.

Configuration
REQ-031 With BALL_SPEEDUP_EN defined: each time score crosses a multiple of 32, the registered ball_vy SHALL increment by 1, capped at 7.
REQ-032 With BALL_SPEEDUP_EN undefined: velocities SHALL pass through unchanged from next_ball_vx/vy.

Structure
REQ-033 Package breakout_pkg SHALL hold: state encoding, H = 640, V = 480, BALL_W = 16, BALL_H = 10, BOARD_Y = 467, LEVEL0_MAP, LEVEL0_COUNT.
REQ-034 Sub-module brick_clear_counter SHALL compute cleared combinationally from bricks and next_bricks.

Verification
REQ-035 Reset, then launch_btn, then tick → state = 2, ball registered from next_* on the following tick.
REQ-036 PLAY tick with 2 fields cleared and collision_trig = 1 → score +2, bricks_left −2, hit_pulse high for 1 cycle.
REQ-037 ball_y = 520, dir = 2'b01, vy = 3, lives = 2 → lives = 1, state = SERVE, ball_y = 455.
REQ-038 Same as REQ-037 with lives = 1 → state = OVER, game_over = 1; launch_btn → IDLE, lives = 3, score = 0.
REQ-039 Final brick cleared on the same tick as lost → state = CLEAR, lives unchanged.
REQ-040 rst_n pulsed low mid-PLAY, asynchronous to clk → outputs at reset values before the next clk edge.
